ipml_prefetch_fifo_sync_v2: RTL



---
 rtl/ipml_prefetch_fifo_sync_v2_if.sv | 28 ++
 rtl/ipml_prefetch_fifo_sync_v2.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ipml_prefetch_fifo_sync_v2_if.sv
// Handshake bundle for ipml_prefetch_fifo_sync_v2: write side, read side,
// flush control and status outputs. Clock and reset stay as plain ports.
interface ipml_prefetch_fifo_sync_v2_if #(
  parameter int c_DATA_WIDTH  = 32,
  parameter int c_DEPTH_WIDTH = 9
);
  logic                    flush;
  logic [c_DATA_WIDTH-1:0] wr_data;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [c_DATA_WIDTH-1:0] rd_data;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [c_DEPTH_WIDTH:0]  count;
  logic                    almost_full;
  logic                    almost_empty;
  logic                    overflow;

  modport master (
    output flush, wr_data, wr_valid, rd_ready,
    input  wr_ready, rd_data, rd_valid, count, almost_full, almost_empty, overflow
  );

  modport slave (
    input  flush, wr_data, wr_valid, rd_ready,
    output wr_ready, rd_data, rd_valid, count, almost_full, almost_empty, overflow
  );
endinterface

// File: rtl/ipml_prefetch_fifo_sync_v2.sv
// Single-clock first-word-fall-through FIFO. A synchronous-read memory feeds
// a 2-entry output register stage through a one-deep in-flight read slot.
// Provides a total-occupancy counter, almost flags, flush and sticky overflow.
module ipml_prefetch_fifo_sync_v2 #(
  parameter int c_DATA_WIDTH  = 32,
  parameter int c_DEPTH_WIDTH = 9,
  parameter int c_AF_LEVEL    = (1 << c_DEPTH_WIDTH) - 2,
  parameter int c_AE_LEVEL    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ipml_prefetch_fifo_sync_v2_if.slave bus
);

  localparam int unsigned DEPTH = 1 << c_DEPTH_WIDTH;
  localparam int          PW    = c_DEPTH_WIDTH + 1;

  typedef logic [PW-1:0]           ptr_t;
  typedef logic [c_DATA_WIDTH-1:0] word_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam ptr_t AF_LVL  = ptr_t'(c_AF_LEVEL);
  localparam ptr_t AE_LVL  = ptr_t'(c_AE_LEVEL);

  word_t      mem [DEPTH];
  word_t      mem_q;
  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  ptr_t       count_q;
  ptr_t       count_nxt;
  logic       mem_empty;
  logic       mem_full;
  logic       wr_fire;
  logic       pop;
  logic       rd_en;
  logic       rd_pend;
  word_t      ost0;
  word_t      ost1;
  logic [1:0] ost_cnt;
  logic       af_q;
  logic       ae_q;
  logic       ovf_q;

  // Handshake qualification, prefetch issue decision and next occupancy.
  always_comb begin
    mem_empty = (wr_ptr == rd_ptr);
    mem_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    wr_fire   = bus.wr_valid & ~mem_full & ~bus.flush;
    pop       = (ost_cnt != 2'd0) & bus.rd_ready & ~bus.flush;
    // A pop in this cycle frees its slot in time for a read issued now.
    rd_en     = ~mem_empty & ~bus.flush &
                ((ost_cnt + {1'b0, rd_pend} - {1'b0, pop}) < 2'd2);
    count_nxt = count_q + ptr_t'(wr_fire) - ptr_t'(pop);
  end

  // Memory array: write port and 1-cycle synchronous read port, no reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[PW-2:0]] <= bus.wr_data;
    if (rd_en)   mem_q <= mem[rd_ptr[PW-2:0]];
  end

  // Pointers, in-flight read flag, occupancy counter and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
      count_q <= '0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
      count_q <= '0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en)   rd_ptr <= rd_ptr + PTR_ONE;
      rd_pend <= rd_en;
      count_q <= count_nxt;
      af_q    <= (count_nxt >= AF_LVL);
      ae_q    <= (count_nxt <= AE_LVL);
      ovf_q   <= ovf_q | (bus.wr_valid & mem_full);
    end
  end

  // Two-entry output stage: ost0 is always the head word shown on rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ost0    <= '0;
      ost1    <= '0;
      ost_cnt <= 2'd0;
    end else if (bus.flush) begin
      ost0    <= '0;
      ost1    <= '0;
      ost_cnt <= 2'd0;
    end else begin
      case ({pop, rd_pend})
        2'b01: begin
          if (ost_cnt == 2'd0) ost0 <= mem_q;
          else                 ost1 <= mem_q;
          ost_cnt <= ost_cnt + 2'd1;
        end
        2'b10: begin
          ost0    <= ost1;
          ost_cnt <= ost_cnt - 2'd1;
        end
        2'b11: begin
          if (ost_cnt == 2'd1) begin
            ost0 <= mem_q;
          end else begin
            ost0 <= ost1;
            ost1 <= mem_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_ready     = ~mem_full;
  assign bus.rd_valid     = (ost_cnt != 2'd0);
  assign bus.rd_data      = ost0;
  assign bus.count        = count_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;

endmodule
